// File: rtl/uart_rx_engine.sv
// UART receive engine: sync, sample and reassemble 7/8-bit frames.
// Optional RX_MAJORITY_EN adds a 3-tap majority glitch filter.
// Ports: clk, reset (async, active-low), baud_value, EIGHT, PEN,
//   OHEL, RX, rd_clr -> rx_data, rx_rdy, perr, ferr, ovf.
`timescale 1ns/1ps

module uart_rx_engine #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] baud_value,
  input  logic       EIGHT,
  input  logic       PEN,
  input  logic       OHEL,
  input  logic       RX,
  input  logic       rd_clr,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  function automatic int kcalc(input int b);
    return (CLK_FREQ + b / 2) / b;
  endfunction

  localparam int K300  = kcalc(300);
  localparam int K1K2  = kcalc(1200);
  localparam int K2K4  = kcalc(2400);
  localparam int K4K8  = kcalc(4800);
  localparam int K9K6  = kcalc(9600);
  localparam int K19K  = kcalc(19200);
  localparam int K38K  = kcalc(38400);
  localparam int K57K  = kcalc(57600);
  localparam int K115K = kcalc(115200);
  localparam int K230K = kcalc(230400);
  localparam int K460K = kcalc(460800);
  localparam int K921K = kcalc(921600);
  localparam int CW    = $clog2(K300 + 1);

  function automatic logic [CW-1:0] bit_time(input logic [3:0] sel);
    logic [CW-1:0] k;
    unique case (sel)
      4'd0:    k = CW'(K300);
      4'd1:    k = CW'(K1K2);
      4'd2:    k = CW'(K2K4);
      4'd3:    k = CW'(K4K8);
      4'd4:    k = CW'(K9K6);
      4'd5:    k = CW'(K19K);
      4'd6:    k = CW'(K38K);
      4'd7:    k = CW'(K57K);
      4'd9:    k = CW'(K230K);
      4'd10:   k = CW'(K460K);
      4'd11:   k = CW'(K921K);
      default: k = CW'(K115K);
    endcase
    return k;
  endfunction

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_q;
  logic                   fall;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          k_cur;
  logic [CW-1:0]          k_live;
  logic                   tick;
  logic [2:0]             bcnt;
  logic [2:0]             last;
  logic [7:0]             sh;
  logic [7:0]             data_w;
  logic [3:0]             baud_q;
  logic                   eight_q;
  logic                   pen_q;
  logic                   ohel_q;
  logic                   par_q;
  logic                   stop_q;
  logic                   done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
  end

`ifdef RX_MAJORITY_EN
  logic [2:0] maj_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) maj_q <= '1;
    else        maj_q <= {maj_q[1:0], sync_q[SYNC_STAGES-1]};
  end

  assign rx_s = (maj_q[0] & maj_q[1]) |
                (maj_q[0] & maj_q[2]) |
                (maj_q[1] & maj_q[2]);
`else
  assign rx_s = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_q <= 1'b1;
    else        rx_q <= rx_s;
  end

  assign fall = rx_q & ~rx_s;

  // The half-bit start check runs before the config is latched,
  // so it uses the live baud select.
  always_comb begin
    k_cur  = bit_time(baud_q);
    k_live = bit_time(baud_value);
    if (state == START) tick = (cnt == (k_live >> 1) - CW'(1));
    else                tick = (cnt == k_cur - CW'(1));
    last   = eight_q ? 3'd7 : 3'd6;
    data_w = eight_q ? sh : {1'b0, sh[7:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (fall) state_d = START;
      START: if (tick) state_d = rx_s ? IDLE : DATA;
      DATA:
        if (tick && bcnt == last)
          state_d = pen_q ? PAR : STOP;
      PAR:   if (tick) state_d = STOP;
      STOP:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bcnt    <= '0;
      sh      <= '0;
      baud_q  <= '0;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      ohel_q  <= 1'b0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state == STOP) && tick;
      if (state == IDLE || tick) cnt <= '0;
      else                       cnt <= cnt + CW'(1);
      if (state == IDLE) bcnt <= '0;
      if (state == START && tick && !rx_s) begin
        baud_q  <= baud_value;
        eight_q <= EIGHT;
        pen_q   <= PEN;
        ohel_q  <= OHEL;
      end
      if (state == DATA && tick) begin
        sh   <= {rx_s, sh[7:1]};
        bcnt <= bcnt + 3'd1;
      end
      if (state == PAR && tick)  par_q  <= rx_s;
      if (state == STOP && tick) stop_q <= rx_s;
    end
  end

  // A completing frame beats a same-cycle read strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data <= '0;
      rx_rdy  <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else if (done) begin
      rx_data <= data_w;
      rx_rdy  <= 1'b1;
      ferr    <= ~stop_q;
      perr    <= pen_q & (^data_w ^ par_q ^ ohel_q);
      ovf     <= rx_rdy & ~rd_clr;
    end else if (rd_clr) begin
      rx_rdy <= 1'b0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
      ovf    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine at a 10 MHz clock.
// Each scenario task drives frames and checks outputs inline.
`timescale 1ns/1ps

module tb_uart_rx_engine;

  localparam int CLK = 10_000_000;
  localparam int K115 = (CLK + 115200 / 2) / 115200;
  localparam int K96  = (CLK + 9600 / 2) / 9600;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] baud_value = 4'd8;
  logic       EIGHT = 1'b1;
  logic       PEN = 1'b0;
  logic       OHEL = 1'b0;
  logic       RX = 1'b1;
  logic       rd_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       perr;
  logic       ferr;
  logic       ovf;

  int n_chk = 0;
  int n_fail = 0;

  uart_rx_engine #(
    .CLK_FREQ(CLK),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .baud_value(baud_value),
    .EIGHT(EIGHT),
    .PEN(PEN),
    .OHEL(OHEL),
    .RX(RX),
    .rd_clr(rd_clr),
    .rx_data(rx_data),
    .rx_rdy(rx_rdy),
    .perr(perr),
    .ferr(ferr),
    .ovf(ovf)
  );

  always #50 clk = ~clk;

  wire [11:0] obs = {rx_data, rx_rdy, perr, ferr, ovf};

  task automatic send_frame(input logic [7:0] d, input int nb,
                            input logic pen, input logic par,
                            input logic stp, input int k);
    @(posedge clk); #1 RX = 1'b0;
    for (int i = 0; i < nb; i++) begin
      repeat (k) @(posedge clk); #1 RX = d[i];
    end
    if (pen) begin
      repeat (k) @(posedge clk); #1 RX = par;
    end
    repeat (k) @(posedge clk); #1 RX = stp;
    repeat (k) @(posedge clk); #1 RX = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic clear_flags();
    @(posedge clk); #1 rd_clr = 1'b1;
    @(posedge clk); #1 rd_clr = 1'b0;
  endtask

  task automatic test_reset();
    #120;
    n_chk++;
    if (obs !== 12'h000) begin
      $display("FAIL reset_out: got %h want 000", obs);
      n_fail++;
    end
    @(negedge clk); reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (obs !== 12'h000) begin
      $display("FAIL idle_out: got %h want 000", obs);
      n_fail++;
    end
  endtask

  task automatic test_basic();
    baud_value = 4'd8; EIGHT = 1'b1; PEN = 1'b0;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, K115);
    @(negedge clk);
    n_chk++;
    if (obs !== {8'hA5, 4'b1000}) begin
      $display("FAIL basic_a5: got %h want a58", obs);
      n_fail++;
    end
    clear_flags();
  endtask

  task automatic test_parity();
    baud_value = 4'd4; EIGHT = 1'b0; PEN = 1'b1; OHEL = 1'b0;
    send_frame(8'h55, 7, 1'b1, 1'b0, 1'b1, K96);
    @(negedge clk);
    n_chk++;
    if (obs !== {8'h55, 4'b1000}) begin
      $display("FAIL par_even_ok: got %h want 558", obs);
      n_fail++;
    end
    clear_flags();
    send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1, K96);
    @(negedge clk);
    n_chk++;
    if (obs !== {8'h55, 4'b1100}) begin
      $display("FAIL par_even_bad: got %h want 55c", obs);
      n_fail++;
    end
    clear_flags();
    OHEL = 1'b1;
    fork
      send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1, K96);
      begin
        repeat (3000) @(posedge clk);
        #1 OHEL = 1'b0; EIGHT = 1'b1;
      end
    join
    @(negedge clk);
    n_chk++;
    if (obs !== {8'h55, 4'b1000}) begin
      $display("FAIL par_odd_cfg: got %h want 558", obs);
      n_fail++;
    end
    clear_flags();
    PEN = 1'b0; EIGHT = 1'b1; baud_value = 4'd8;
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, K115);
    @(negedge clk);
    n_chk++;
    if (obs !== {8'h3C, 4'b1010}) begin
      $display("FAIL ferr_set: got %h want 3ca", obs);
      n_fail++;
    end
    clear_flags();
    @(negedge clk);
    n_chk++;
    if (obs !== {8'h3C, 4'b0000}) begin
      $display("FAIL ferr_clr: got %h want 3c0", obs);
      n_fail++;
    end
  endtask

  task automatic test_glitch();
    @(posedge clk); #1 RX = 1'b0;
    repeat (2) @(posedge clk); #1 RX = 1'b1;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (obs !== {8'h3C, 4'b0000}) begin
      $display("FAIL glitch_rej: got %h want 3c0", obs);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int done_at;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, K115);
    @(negedge clk);
    n_chk++;
    if (obs !== {8'h11, 4'b1000}) begin
      $display("FAIL b2b_first: got %h want 118", obs);
      n_fail++;
    end
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, K115);
    @(negedge clk);
    n_chk++;
    if (obs !== {8'h22, 4'b1001}) begin
      $display("FAIL b2b_ovf: got %h want 229", obs);
      n_fail++;
    end
    // completion edge: sync + half bit + 9 bit times + 1
    done_at = 3 + K115 / 2 + 9 * K115 + 1;
`ifdef RX_MAJORITY_EN
    done_at = done_at + 2;
`endif
    fork
      send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, K115);
      begin
        @(posedge clk);
        repeat (done_at - 1) @(posedge clk);
        #1 rd_clr = 1'b1;
        @(posedge clk); #1 rd_clr = 1'b0;
      end
    join
    @(negedge clk);
    n_chk++;
    if (obs !== {8'h33, 4'b1000}) begin
      $display("FAIL b2b_clr_win: got %h want 338", obs);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    fork
      send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, K115);
      begin
        @(posedge clk);
        repeat (4 * K115 + 40) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (obs !== 12'h000) begin
          $display("FAIL rst_mid: got %h want 000", obs);
          n_fail++;
        end
        reset = 1'b1;
      end
    join
    @(negedge clk);
    n_chk++;
    if (obs !== 12'h000) begin
      $display("FAIL rst_discard: got %h want 000", obs);
      n_fail++;
    end
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, K115);
    @(negedge clk);
    n_chk++;
    if (obs !== {8'h12, 4'b1000}) begin
      $display("FAIL rst_next: got %h want 128", obs);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
